key_matrix_emu: RTL and testbench

Synthesizable 4x4 matrix-keypad emulator: the keypad end of the row/column scan interface.
- A host (test sequencer, UART command block, self-test logic) requests a key press by code.
- The block drives active-low row lines in response to the scanner's active-low column drive, for a press/hold/release sequence with optional contact bounce.
- Used for hardware-in-the-loop and regression checking of the keypad scanner without a physical keypad.

---
 rtl/key_matrix_emu.sv | 184 ++++++++++++++++++
 tb/tb_key_matrix_emu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_emu.sv
// -----------------------------------------------------------------------------
// key_matrix_emu
//
// Keypad end of a 4x4 row/column scan interface. A host requests a key press by
// code; the block then plays a press / hold / release sequence and answers the
// scanner's active-low column drive on the active-low row lines, exactly as a
// physical switch at (krow, kcol) would.
//
// Optional feature (macro KEY_EMU_BOUNCE_EN):
//   defined   - press and release are each preceded by a bounce window in which
//               the contact chatters from a 16-bit LFSR.
//   undefined - no bounce states, no LFSR; the contact closes on the accept
//               edge, stays closed for HOLD_CYCLES, then opens.
//
// Parameters:
//   HOLD_CYCLES    stable-contact duration in clk cycles (1..2^26)
//   BOUNCE_CYCLES  length of each bounce window in clk cycles (1..2^26)
//   BOUNCE_STEP    clk cycles between contact changes while bouncing
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   key_col_i  column drive from the scanner, active-low (0 = selected)
//   key_row_o  row lines to the scanner, active-low, idle 4'b1111
//   press_req  press request strobe, honoured only while idle
//   press_key  key code {row[1:0], col[1:0]}, captured with press_req
//   busy       high while a sequence is in progress (state != IDLE)
//   done       one-cycle pulse at the end of a sequence
//   contact    current emulated switch contact (1 = closed)
// -----------------------------------------------------------------------------
module key_matrix_emu #(
  parameter int unsigned HOLD_CYCLES   = 2_500_000,
  parameter int unsigned BOUNCE_CYCLES = 250_000,
  parameter int unsigned BOUNCE_STEP   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_col_i,
  output logic [3:0] key_row_o,
  input  logic       press_req,
  input  logic [3:0] press_key,
  output logic       busy,
  output logic       done,
  output logic       contact
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > (1 << 26) ||
      BOUNCE_CYCLES < 1 || BOUNCE_CYCLES > (1 << 26) ||
      BOUNCE_STEP < 1 || BOUNCE_STEP > BOUNCE_CYCLES) begin : g_param_check
    $error("key_matrix_emu: timing parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_P,
    S_HOLD,
    S_BOUNCE_R,
    S_DONE
  } state_t;

  // A state exits on the edge where the counter reaches limit-1.
  localparam logic [25:0] HOLD_LIM = 26'(HOLD_CYCLES - 1);

  state_t      state;
  logic [25:0] cnt;
  logic [1:0]  krow;
  logic [1:0]  kcol;
  logic [3:0]  row_next;

`ifdef KEY_EMU_BOUNCE_EN
  localparam logic [25:0] BOUNCE_LIM = 26'(BOUNCE_CYCLES - 1);
  localparam logic [25:0] STEP_LIM   = 26'(BOUNCE_STEP - 1);

  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [25:0] step_cnt;

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0.
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`endif

  // The switch connects row krow to column kcol: the row is pulled low only
  // while the contact is closed and the scanner drives that column low.
  always_comb begin
    // NOTE: default first so every path assigns row_next; otherwise a latch is inferred.
    row_next = 4'b1111;
    if (contact && !key_col_i[kcol]) row_next[krow] = 1'b0;
  end

  // NOTE: reset is sampled on the clock edge only; rst is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      krow      <= '0;
      kcol      <= '0;
      key_row_o <= 4'b1111;
      busy      <= 1'b0;
      done      <= 1'b0;
      contact   <= 1'b0;
`ifdef KEY_EMU_BOUNCE_EN
      lfsr      <= 16'hACE1;
      step_cnt  <= '0;
`endif
    end else begin
      // NOTE: non-blocking everywhere here, so every register sees pre-edge values.
      key_row_o <= row_next;
      done      <= 1'b0;
      cnt       <= cnt + 26'd1;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (press_req) begin
            krow    <= press_key[3:2];
            kcol    <= press_key[1:0];
            contact <= 1'b1;
            busy    <= 1'b1;
`ifdef KEY_EMU_BOUNCE_EN
            state    <= S_BOUNCE_P;
            step_cnt <= '0;
`else
            state    <= S_HOLD;
`endif
          end
        end

`ifdef KEY_EMU_BOUNCE_EN
        // Both bounce windows share timing; only the exit target and the
        // settled contact value differ. The exit edge takes precedence over
        // a coinciding bounce step.
        S_BOUNCE_P, S_BOUNCE_R: begin
          if (cnt == BOUNCE_LIM) begin
            cnt      <= '0;
            step_cnt <= '0;
            if (state == S_BOUNCE_P) begin
              state   <= S_HOLD;
              contact <= 1'b1;
            end else begin
              state   <= S_DONE;
              contact <= 1'b0;
              done    <= 1'b1;
            end
          end else if (step_cnt == STEP_LIM) begin
            step_cnt <= '0;
            lfsr     <= lfsr_next;
            contact  <= lfsr_next[0];
          end else begin
            step_cnt <= step_cnt + 26'd1;
          end
        end
`endif

        S_HOLD: begin
          if (cnt == HOLD_LIM) begin
            cnt     <= '0;
            contact <= 1'b0;
`ifdef KEY_EMU_BOUNCE_EN
            state    <= S_BOUNCE_R;
            step_cnt <= '0;
`else
            state    <= S_DONE;
            done     <= 1'b1;
`endif
          end
        end

        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          cnt     <= '0;
          state   <= S_IDLE;
          busy    <= 1'b0;
          contact <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_matrix_emu.sv
// -----------------------------------------------------------------------------
// tb_key_matrix_emu
//
// Directed bench for key_matrix_emu with HOLD_CYCLES=100, BOUNCE_CYCLES=40,
// BOUNCE_STEP=4. Expectations follow the build: with KEY_EMU_BOUNCE_EN the
// sequence carries two 40-cycle bounce windows whose contact values come from
// a reference LFSR seeded 16'hACE1; without it the sequence is hold + done.
// -----------------------------------------------------------------------------
module tb_key_matrix_emu;

  localparam int HOLD = 100;
  localparam int STEP = 4;
`ifdef KEY_EMU_BOUNCE_EN
  localparam int BNC = 40;
`else
  localparam int BNC = 0;
`endif
  // Edges after the accept edge at which done is high.
  localparam int DONE_N = 2 * BNC + HOLD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_col_i = 4'b1111;
  logic [3:0] key_row_o;
  logic       press_req = 1'b0;
  logic [3:0] press_key = 4'd0;
  logic       busy;
  logic       done;
  logic       contact;

  int checks   = 0;
  int failures = 0;

  logic [15:0] ref_lfsr = 16'hACE1;
  logic [3:0]  sweep_col [6];
  logic [3:0]  sweep_row [6];

  always #5 clk = ~clk;

  key_matrix_emu #(
    .HOLD_CYCLES  (HOLD),
    .BOUNCE_CYCLES(40),
    .BOUNCE_STEP  (STEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_col_i(key_col_i),
    .key_row_o(key_row_o),
    .press_req(press_req),
    .press_key(press_key),
    .busy     (busy),
    .done     (done),
    .contact  (contact)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_step();
    ref_lfsr = {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5], ref_lfsr[15:1]};
  endtask

  // One full press sequence with a per-cycle expected contact/row/busy/done.
  //   sweep     : walk the column table through six hold cycles
  //   extra_req : re-request key 9 while busy and in the DONE cycle
  //   rst_at    : pulse reset before edge n (0 = never)
  //   hold_row  : hand-computed row value checked in the middle of HOLD
  task automatic run_seq(input string tag, input logic [3:0] key, input logic [3:0] col,
                         input bit sweep, input bit extra_req, input int rst_at,
                         input logic [3:0] hold_row);
    logic       exp_c;
    logic       prev_c;
    logic [3:0] col_now;
    logic [3:0] exp_row;
    logic [1:0] kr;
    logic [1:0] kc;
    int         m;
    kr = key[3:2];
    kc = key[1:0];
    press_key = key;
    key_col_i = col;
    press_req = 1'b1;
    tick();
    press_req = 1'b0;
    exp_c = 1'b1;
    check({tag, "_acc_busy"},    4'(busy),    4'd1);
    check({tag, "_acc_contact"}, 4'(contact), 4'd1);
    check({tag, "_acc_done"},    4'(done),    4'd0);

    for (int n = 1; n <= DONE_N + 1; n++) begin
      col_now = col;
      if (sweep && n >= BNC + 10 && n < BNC + 16) col_now = sweep_col[n - BNC - 10];
      key_col_i = col_now;
      if (extra_req && (n == 5 || n == DONE_N + 1)) begin
        press_req = 1'b1;
        press_key = 4'd9;
      end else begin
        press_req = 1'b0;
      end
      if (n == rst_at) rst = 1'b0;

      prev_c = exp_c;
      if (BNC > 0) begin
        m = n - BNC - HOLD;
        if (n < BNC) begin
          if (n % STEP == 0) begin
            ref_step();
            exp_c = ref_lfsr[0];
          end
        end else if (n < BNC + HOLD) begin
          exp_c = 1'b1;
        end else if (n == BNC + HOLD) begin
          exp_c = 1'b0;
        end else if (n < DONE_N) begin
          if (m % STEP == 0) begin
            ref_step();
            exp_c = ref_lfsr[0];
          end
        end else begin
          exp_c = 1'b0;
        end
      end else begin
        exp_c = (n < HOLD);
      end
      exp_row = 4'b1111;
      if (prev_c && !col_now[kc]) exp_row[kr] = 1'b0;

      tick();

      if (n == rst_at) begin
        check({tag, "_rst_row"},     key_row_o,   4'b1111);
        check({tag, "_rst_busy"},    4'(busy),    4'd0);
        check({tag, "_rst_done"},    4'(done),    4'd0);
        check({tag, "_rst_contact"}, 4'(contact), 4'd0);
        rst       = 1'b1;
        press_req = 1'b0;
        ref_lfsr  = 16'hACE1;
        return;
      end

      check({tag, "_row"},     key_row_o,   exp_row);
      check({tag, "_contact"}, 4'(contact), 4'(exp_c));
      check({tag, "_busy"},    4'(busy),    (n <= DONE_N) ? 4'd1 : 4'd0);
      check({tag, "_done"},    4'(done),    (n == DONE_N) ? 4'd1 : 4'd0);
      if (n == BNC + 50) check({tag, "_hold_row"}, key_row_o, hold_row);
      if (sweep && n >= BNC + 10 && n < BNC + 16)
        check({tag, "_sweep"}, key_row_o, sweep_row[n - BNC - 10]);
    end
    press_req = 1'b0;
  endtask

  initial begin
    sweep_col[0] = 4'b1110; sweep_row[0] = 4'b1111;
    sweep_col[1] = 4'b1101; sweep_row[1] = 4'b1111;
    sweep_col[2] = 4'b1011; sweep_row[2] = 4'b1111;
    sweep_col[3] = 4'b0111; sweep_row[3] = 4'b0111;
    sweep_col[4] = 4'b0000; sweep_row[4] = 4'b0111;
    sweep_col[5] = 4'b1111; sweep_row[5] = 4'b1111;

    // Reset state.
    rst = 1'b0;
    tick();
    tick();
    check("reset_row",     key_row_o,   4'b1111);
    check("reset_busy",    4'(busy),    4'd0);
    check("reset_done",    4'(done),    4'd0);
    check("reset_contact", 4'(contact), 4'd0);
    rst = 1'b1;

    // Idle with the scanner in detect mode: no key closed, rows stay high.
    key_col_i = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_row",  key_row_o, 4'b1111);
      check("idle_busy", 4'(busy),  4'd0);
    end

    // Basic press: key 6 (row1,col2), column 2 selected.
    run_seq("basic", 4'd6, 4'b1011, 1'b0, 1'b0, 0, 4'b1101);
    check("basic_end_row",  key_row_o, 4'b1111);
    check("basic_end_busy", 4'(busy),  4'd0);
    tick();

    // Column sweep during HOLD of key 15.
    run_seq("sweep", 4'd15, 4'b1111, 1'b1, 1'b0, 0, 4'b1111);
    tick();

    // Bounce / detect mode on key 0.
    run_seq("key0", 4'd0, 4'b0000, 1'b0, 1'b0, 0, 4'b1110);
    tick();

    // Key 5 in detect mode.
    run_seq("key5", 4'd5, 4'b0000, 1'b0, 1'b0, 0, 4'b1101);
    tick();

    // Requests while busy and in the DONE cycle are dropped.
    run_seq("ignore", 4'd3, 4'b0111, 1'b0, 1'b1, 0, 4'b1110);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ignore_idle_busy", 4'(busy),    4'd0);
      check("ignore_idle_cont", 4'(contact), 4'd0);
    end
    press_key = 4'd0;

    // Mid-sequence reset in HOLD: abandoned with no done pulse.
    run_seq("abort", 4'd10, 4'b1011, 1'b0, 1'b0, BNC + 60, 4'b1011);
    for (int i = 0; i < DONE_N + 5; i++) begin
      tick();
      check("abort_no_done", 4'(done), 4'd0);
      check("abort_no_busy", 4'(busy), 4'd0);
    end
    run_seq("after_abort", 4'd10, 4'b1011, 1'b0, 1'b0, 0, 4'b1011);
    tick();
    check("final_row",  key_row_o, 4'b1111);
    check("final_busy", 4'(busy),  4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
